// File: rtl/pe_pkg.sv
// Shared constants, weight-buffer state encoding and the saturating adder
// used by the processing-element datapath.
package pe_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_FRAC_W = 8;
   localparam int DEF_ACC_W  = 32;

   // Shadow weight register occupancy
   typedef enum logic {
      W_EMPTY = 1'b0,
      W_FULL  = 1'b1
   } wstate_t;

   // Adds two sign-extended operands and clamps the result to a signed
   // aw-bit range. ovf reports that clamping took place. Operands are
   // carried at 64 bits so one function serves any accumulator width up
   // to 62 bits; the sum of two aw-bit values always fits in aw+1 bits.
   function automatic logic signed [63:0] sat_add(
      input  logic signed [63:0] a,
      input  logic signed [63:0] b,
      input  int                 aw,
      output logic               ovf
   );
      logic signed [63:0] s, hi, lo;
      hi  = (64'sd1 <<< (aw - 1)) - 64'sd1;
      lo  = -hi - 64'sd1;
      s   = a + b;
      ovf = (s > hi) || (s < lo);
      if (s > hi)      return hi;
      else if (s < lo) return lo;
      else             return s;
   endfunction

endpackage

// File: rtl/pe_mac_dp.sv
// Combinational signed fixed-point multiply, Q-realign and saturating
// accumulate. Holds no state so it can be shared with the bias unit.
module pe_mac_dp
   import pe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int ACC_W  = DEF_ACC_W   // must be >= 2*DATA_W-FRAC_W
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] w,
   input  logic signed [ACC_W-1:0]  sum_in,
   output logic signed [ACC_W-1:0]  sum_out,
   output logic                     sat
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [2*DATA_W-1:0] scaled;

   // Full-precision product, realigned to the Q format; the arithmetic
   // shift rounds toward negative infinity
   assign prod   = a * w;
   assign scaled = prod >>> FRAC_W;

   // Accumulate onto the incoming partial sum and clamp to ACC_W
   always_comb begin
      sat     = 1'b0;
      sum_out = ACC_W'(sat_add(64'(scaled), 64'(sum_in), ACC_W, sat));
   end

endmodule

// File: rtl/pe_mac.sv
// Weight-stationary systolic PE: one-cycle MAC stage, double-buffered
// weights with a forwarded switch wave, and sticky error flags.
module pe_mac
   import pe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] input_in,
   input  logic [ACC_W-1:0]  sum_in,
   input  logic              load_weight,
   input  logic [DATA_W-1:0] weight_in,
   input  logic              switch_in,
   input  logic              clear_flags,
   output logic              valid_out,
   output logic [DATA_W-1:0] input_out,
   output logic [ACC_W-1:0]  sum_out,
   output logic [DATA_W-1:0] weight_out,
   output logic              switch_out,
   output logic              ovf,
   output logic              weight_err
);

   wstate_t           state_q, state_d;
   logic [DATA_W-1:0] w_act, w_act_d;
   logic [DATA_W-1:0] w_shd, w_shd_d;
   logic              err_set;
   logic [ACC_W-1:0]  mac_sum;
   logic              mac_sat;

   // The shadow register doubles as this column's weight shift chain
   assign weight_out = w_shd;

   pe_mac_dp #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_dp (
      .a       (input_in),
      .w       (w_act),
      .sum_in  (sum_in),
      .sum_out (mac_sum),
      .sat     (mac_sat)
   );

   // Weight buffer next state: a switch promotes a full shadow, a load
   // refills it; a load in the same cycle leaves the shadow full again
   always_comb begin
      state_d = state_q;
      w_act_d = w_act;
      w_shd_d = w_shd;
      err_set = 1'b0;
      if (switch_in) begin
         if (state_q == W_FULL) begin
            w_act_d = w_shd;
            state_d = W_EMPTY;
         end else begin
            err_set = 1'b1;
         end
      end
      if (load_weight) begin
         w_shd_d = weight_in;
         state_d = W_FULL;
      end
   end

   // Weight buffer registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= W_EMPTY;
         w_act   <= '0;
         w_shd   <= '0;
      end else begin
         state_q <= state_d;
         w_act   <= w_act_d;
         w_shd   <= w_shd_d;
      end
   end

   // Pipeline stage; bubbles propagate as all-zero words
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_out  <= 1'b0;
         input_out  <= '0;
         sum_out    <= '0;
         switch_out <= 1'b0;
      end else begin
         valid_out  <= valid_in;
         input_out  <= valid_in ? input_in : '0;
         sum_out    <= valid_in ? mac_sum  : '0;
         switch_out <= switch_in;
      end
   end

   // Sticky flags; a set event outranks a clear in the same cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf        <= 1'b0;
         weight_err <= 1'b0;
      end else begin
         ovf        <= (valid_in & mac_sat) | (ovf & ~clear_flags);
         weight_err <= err_set | (weight_err & ~clear_flags);
      end
   end

endmodule

// File: tb/tb_pe_mac.sv
// Directed bench for pe_mac with a scoreboard of expected pipeline outputs.
module tb_pe_mac;

   localparam int DW = 16;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          valid_in = 1'b0;
   logic [DW-1:0] input_in = '0;
   logic [AW-1:0] sum_in = '0;
   logic          load_weight = 1'b0;
   logic [DW-1:0] weight_in = '0;
   logic          switch_in = 1'b0;
   logic          clear_flags = 1'b0;
   logic          valid_out;
   logic [DW-1:0] input_out;
   logic [AW-1:0] sum_out;
   logic [DW-1:0] weight_out;
   logic          switch_out;
   logic          ovf;
   logic          weight_err;

   pe_mac dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .valid_in    (valid_in),
      .input_in    (input_in),
      .sum_in      (sum_in),
      .load_weight (load_weight),
      .weight_in   (weight_in),
      .switch_in   (switch_in),
      .clear_flags (clear_flags),
      .valid_out   (valid_out),
      .input_out   (input_out),
      .sum_out     (sum_out),
      .weight_out  (weight_out),
      .switch_out  (switch_out),
      .ovf         (ovf),
      .weight_err  (weight_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          v;
      logic [DW-1:0] i;
      logic [AW-1:0] s;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, queue the expected pipeline output, then compare it
   // one edge later
   task automatic step(input logic v, input logic [DW-1:0] in, input logic [AW-1:0] s,
                       input logic [AW-1:0] exp_s, input logic ld = 1'b0,
                       input logic [DW-1:0] w = '0, input logic sw = 1'b0,
                       input logic clr = 1'b0);
      exp_t e;
      valid_in = v; input_in = in; sum_in = s;
      load_weight = ld; weight_in = w; switch_in = sw; clear_flags = clr;
      sbq.push_back('{v, (v ? in : 16'h0), (v ? exp_s : 32'h0)});
      @(posedge clk); #1;
      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sbq.pop_front();
         chk("valid_out", 64'(valid_out), 64'(e.v));
         chk("input_out", 64'(input_out), 64'(e.i));
         chk("sum_out",   64'(sum_out),   64'(e.s));
      end
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_valid_out",  64'(valid_out),  64'd0);
      chk("rst_sum_out",    64'(sum_out),    64'd0);
      chk("rst_input_out",  64'(input_out),  64'd0);
      chk("rst_weight_out", 64'(weight_out), 64'd0);
      chk("rst_switch_out", 64'(switch_out), 64'd0);
      chk("rst_ovf",        64'(ovf),        64'd0);
      chk("rst_weight_err", 64'(weight_err), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Basic MAC: w = 2.0, 1.5*2.0 + 1.0 = 4.0
      step(1'b0, 16'h0, 32'h0, 32'h0, 1'b1, 16'h0200);
      chk("load_weight_out", 64'(weight_out), 64'h0200);
      step(1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 16'h0, 1'b1);
      chk("switch_out_pulse", 64'(switch_out), 64'd1);
      chk("first_switch_no_err", 64'(weight_err), 64'd0);
      step(1'b1, 16'h0180, 32'h0000_0100, 32'h0000_0400);
      chk("switch_out_drop", 64'(switch_out), 64'd0);

      // Negative operand
      step(1'b1, 16'hFF00, 32'h0, 32'hFFFF_FE00);
      chk("ovf_clean", 64'(ovf), 64'd0);

      // Positive saturation, sticky until cleared
      step(1'b1, 16'h0180, 32'h7FFF_FF00, 32'h7FFF_FFFF);
      chk("ovf_set", 64'(ovf), 64'd1);
      step(1'b0, 16'h0, 32'h0, 32'h0);
      chk("ovf_sticky1", 64'(ovf), 64'd1);
      step(1'b1, 16'h0100, 32'h0, 32'h0000_0200);
      chk("ovf_sticky2", 64'(ovf), 64'd1);
      step(1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      chk("ovf_cleared", 64'(ovf), 64'd0);

      // Negative saturation coinciding with clear: set wins
      step(1'b1, 16'hFF00, 32'h8000_0000, 32'h8000_0000, 1'b0, 16'h0, 1'b0, 1'b1);
      chk("ovf_set_beats_clear", 64'(ovf), 64'd1);
      step(1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      chk("ovf_cleared2", 64'(ovf), 64'd0);

      // Double buffering: shadow loads while the old weight keeps computing
      step(1'b1, 16'h0100, 32'h0, 32'h0000_0200, 1'b1, 16'h0100);
      chk("shadow_1_0", 64'(weight_out), 64'h0100);
      step(1'b1, 16'h0100, 32'h0000_0200, 32'h0000_0400);
      step(1'b1, 16'h0100, 32'h0000_0400, 32'h0000_0600, 1'b0, 16'h0, 1'b1);
      chk("switch_out_db", 64'(switch_out), 64'd1);
      step(1'b1, 16'h0100, 32'h0000_0600, 32'h0000_0700);
      chk("switch_out_db_drop", 64'(switch_out), 64'd0);
      step(1'b1, 16'h0100, 32'h0000_0700, 32'h0000_0800);

      // Simultaneous load and switch with a full shadow
      step(1'b0, 16'h0, 32'h0, 32'h0, 1'b1, 16'h0300);
      step(1'b0, 16'h0, 32'h0, 32'h0, 1'b1, 16'h0400, 1'b1);
      chk("simul_shadow", 64'(weight_out), 64'h0400);
      chk("simul_no_err", 64'(weight_err), 64'd0);
      step(1'b1, 16'h0100, 32'h0, 32'h0000_0300);
      step(1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 16'h0, 1'b1);
      chk("full_switch_no_err", 64'(weight_err), 64'd0);
      step(1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 16'h0, 1'b1);
      chk("empty_switch_err", 64'(weight_err), 64'd1);
      step(1'b1, 16'h0100, 32'h0, 32'h0000_0400);
      chk("weight_err_sticky", 64'(weight_err), 64'd1);
      step(1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b1);
      chk("weight_err_cleared", 64'(weight_err), 64'd0);

      // Mid-stream asynchronous reset
      step(1'b1, 16'h0100, 32'h0000_0055, 32'h0000_0455);
      #2 reset_n = 1'b0;
      #1;
      chk("async_valid_out",  64'(valid_out),  64'd0);
      chk("async_sum_out",    64'(sum_out),    64'd0);
      chk("async_input_out",  64'(input_out),  64'd0);
      chk("async_weight_out", 64'(weight_out), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Bubble with nonzero data, then weight back at zero
      step(1'b0, 16'h1234, 32'h5678_9ABC, 32'h0);
      step(1'b1, 16'h0100, 32'h0000_0055, 32'h0000_0055);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
